// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host receiver: synchronises and deglitches the PS/2 lines, deframes
// 11-bit frames, strips E0/F0 prefixes and emits one strobe per key-press event.
module ps2_key_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 5400
) (
    input  logic       clock27,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] keyDataOut,
    output logic       key_valid,
    output logic       frame_err
);

    // state  | meaning
    // IDLE   | bus idle, waiting for a start bit (data=0 on a strobe)
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | capturing the odd-parity bit
    // STOP   | checking stop bit and parity, then decoding the byte
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_RELOAD = FW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [FW-1:0]          filt_cnt;
    logic                   clk_filt;
    logic                   clk_filt_d;
    logic                   strobe;
    logic                   data_bit;

    state_t                 state;
    logic [2:0]             bitcnt;
    logic [7:0]             shift_reg;
    logic                   parity_bit;
    logic                   ext;
    logic                   brk;
    logic [TW-1:0]          to_cnt;
    logic                   to_expire;

    assign strobe    = clk_filt_d & ~clk_filt;
    assign data_bit  = data_sync[SYNC_STAGES-1];
    assign to_expire = (state != IDLE) && (to_cnt == TO_LAST);

    // Synchronisers idle high so a reset never looks like a falling edge.
    always_ff @(posedge clock27) begin
        if (reset) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            filt_cnt   <= FILT_RELOAD;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_filt_d <= clk_filt;
            if (clk_sync[SYNC_STAGES-1] == clk_filt) begin
                filt_cnt <= FILT_RELOAD;
            end else if (filt_cnt == '0) begin
                clk_filt <= clk_sync[SYNC_STAGES-1];
                filt_cnt <= FILT_RELOAD;
            end else begin
                filt_cnt <= filt_cnt - FW'(1);
            end
        end
    end

    always_ff @(posedge clock27) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            to_cnt     <= '0;
            keyDataOut <= 9'h000;
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            if (to_expire) begin
                // Expiry beats a coincident strobe; the partial byte is dropped.
                state     <= IDLE;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
                to_cnt    <= '0;
            end else begin
                if (strobe || state == IDLE) to_cnt <= '0;
                else                         to_cnt <= to_cnt + TW'(1);
                if (strobe) begin
                    case (state)
                        IDLE: begin
                            if (!data_bit) begin
                                state  <= DATA;
                                bitcnt <= 3'd0;
                            end
                        end
                        DATA: begin
                            shift_reg <= {data_bit, shift_reg[7:1]};
                            if (bitcnt == 3'd7) state <= PARITY;
                            else                bitcnt <= bitcnt + 3'd1;
                        end
                        PARITY: begin
                            parity_bit <= data_bit;
                            state      <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (data_bit && (^{shift_reg, parity_bit})) begin
                                if (shift_reg == 8'hE0) begin
                                    ext <= 1'b1;
                                end else if (shift_reg == 8'hF0) begin
                                    brk <= 1'b1;
                                end else if (brk) begin
                                    ext <= 1'b0;
                                    brk <= 1'b0;
                                end else begin
                                    keyDataOut <= {ext, shift_reg};
                                    key_valid  <= 1'b1;
                                    ext        <= 1'b0;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                ext       <= 1'b0;
                                brk       <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: drives PS/2 frames and compares the observed event
// stream against a byte-level prefix/parity model.
module tb_ps2_key_receiver;

    localparam int HALF    = 40;
    localparam int TIMEOUT = 5400;

    logic       clock27 = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] keyDataOut;
    logic       key_valid;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    // Events: bit 9 = frame error, bits 8:0 = key code.
    logic [9:0] ev_q[$];
    logic [9:0] exp_q[$];
    logic       m_ext  = 1'b0;
    logic       m_brk  = 1'b0;
    logic [8:0] m_last = 9'h000;
    logic       kv_prev = 1'b0;
    logic       fe_prev = 1'b0;

    ps2_key_receiver dut (
        .clock27   (clock27),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keyDataOut(keyDataOut),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 clock27 = ~clock27;

    always @(negedge clock27) begin
        if (key_valid) ev_q.push_back({1'b0, keyDataOut});
        if (frame_err) ev_q.push_back(10'h200);
        if (key_valid || frame_err) begin
            checks++;
            if (key_valid && frame_err) begin
                failures++;
                $display("FAIL pulse_overlap key_valid=%b frame_err=%b required not both", key_valid, frame_err);
            end
            checks++;
            if ((key_valid && kv_prev) || (frame_err && fe_prev)) begin
                failures++;
                $display("FAIL pulse_width kv=%b/%b fe=%b/%b required single-cycle", kv_prev, key_valid, fe_prev, frame_err);
            end
        end
        kv_prev <= key_valid;
        fe_prev <= frame_err;
    end

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            exp_q.push_back(10'h200);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0)     m_brk = 1'b1;
        else if (m_brk) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            m_last = {m_ext, b};
            exp_q.push_back({1'b0, m_ext, b});
            m_ext = 1'b0;
        end
    endtask

    task automatic ps2_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(posedge clock27);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clock27);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(posedge clock27);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clock27);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        ps2_bits({1'b1, par, b, 1'b0}, 11);
        model_byte(b, bad);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (5) @(posedge clock27);
        reset = 1'b0;
        @(negedge clock27);
        checks++;
        if (keyDataOut !== 9'h000) begin failures++; $display("FAIL reset_key got=%h exp=000", keyDataOut); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_make;
        ev_q.delete(); exp_q.delete();
        send_frame(8'h1C, 0);
        checks++;
        if (ev_q.size() != exp_q.size()) begin failures++; $display("FAIL make_count got=%0d exp=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin failures++; $display("FAIL make_event[%0d] got=%h exp=%h", i, ev_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_break;
        ev_q.delete(); exp_q.delete();
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        checks++;
        if (ev_q.size() != 0) begin failures++; $display("FAIL break_silent got=%0d events exp=0", ev_q.size()); end
        checks++;
        if (keyDataOut !== m_last) begin failures++; $display("FAIL break_hold got=%h exp=%h", keyDataOut, m_last); end
        send_frame(8'h1C, 0);
        checks++;
        if (ev_q.size() != exp_q.size()) begin failures++; $display("FAIL break_count got=%0d exp=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin failures++; $display("FAIL break_event[%0d] got=%h exp=%h", i, ev_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_extended;
        ev_q.delete(); exp_q.delete();
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        send_frame(8'h16, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        checks++;
        if (ev_q.size() != exp_q.size()) begin failures++; $display("FAIL ext_count got=%0d exp=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin failures++; $display("FAIL ext_event[%0d] got=%h exp=%h", i, ev_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_parity_error;
        ev_q.delete(); exp_q.delete();
        send_frame(8'h1C, 1);
        send_frame(8'h2B, 0);
        checks++;
        if (ev_q.size() != exp_q.size()) begin failures++; $display("FAIL parity_count got=%0d exp=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin failures++; $display("FAIL parity_event[%0d] got=%h exp=%h", i, ev_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout;
        ev_q.delete(); exp_q.delete();
        ps2_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
        repeat (TIMEOUT + 200) @(posedge clock27);
        model_byte(8'h00, 1);
        send_frame(8'h1C, 0);
        checks++;
        if (ev_q.size() != exp_q.size()) begin failures++; $display("FAIL timeout_count got=%0d exp=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin failures++; $display("FAIL timeout_event[%0d] got=%h exp=%h", i, ev_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_glitch;
        ev_q.delete(); exp_q.delete();
        send_frame(8'hE0, 0);
        ps2_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
        reset = 1'b1;
        repeat (3) @(posedge clock27);
        reset = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; m_last = 9'h000;
        repeat (HALF) @(posedge clock27);
        checks++;
        if (keyDataOut !== m_last) begin failures++; $display("FAIL midreset_key got=%h exp=%h", keyDataOut, m_last); end
        ps2_data = 1'b0;
        repeat (20) @(posedge clock27);
        ps2_clk = 1'b0;
        repeat (4) @(posedge clock27);
        ps2_clk = 1'b1;
        repeat (20) @(posedge clock27);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clock27);
        send_frame(8'h45, 0);
        checks++;
        if (ev_q.size() != exp_q.size()) begin failures++; $display("FAIL glitch_count got=%0d exp=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin failures++; $display("FAIL glitch_event[%0d] got=%h exp=%h", i, ev_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        int r;
        ev_q.delete(); exp_q.delete();
        for (int n = 0; n < 14; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(1, 255));
            if (r == 0)      send_frame(8'hE0, 0);
            else if (r == 1) send_frame(8'hF0, 0);
            else if (r == 2) send_frame(b, 1);
            else             send_frame(b, 0);
        end
        checks++;
        if (ev_q.size() != exp_q.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_event[%0d] got=%h exp=%h", i, ev_q[i], exp_q[i]); end
        end
        checks++;
        if (keyDataOut !== m_last) begin failures++; $display("FAIL random_hold got=%h exp=%h", keyDataOut, m_last); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_error();
        test_timeout();
        test_reset_glitch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
